// File: rtl/s4ga_pkg.sv
// rtl/s4ga_pkg.sv - derived frame/memory sizes and FSM state type for the s4ga config streamer
package s4ga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RSTW = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   function automatic int calc_clog2(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic int calc_n_w(input int n);
      return calc_clog2(n);
   endfunction

   function automatic int calc_mask_w(input int k);
      return 1 << k;
   endfunction

   function automatic int calc_idx_segs(input int n, input int si_w);
      return (calc_n_w(n) + si_w - 1) / si_w;
   endfunction

   function automatic int calc_mask_segs(input int k, input int si_w);
      return (calc_mask_w(k) + si_w - 1) / si_w;
   endfunction

   // Segments per LUT frame: K index fields followed by the mask.
   function automatic int calc_f(input int n, input int k, input int si_w);
      return k * calc_idx_segs(n, si_w) + calc_mask_segs(k, si_w);
   endfunction

   function automatic int calc_depth(input int n, input int k, input int si_w);
      return n * calc_f(n, k, si_w);
   endfunction

   function automatic int calc_a_w(input int n, input int k, input int si_w);
      return calc_clog2(calc_depth(n, k, si_w));
   endfunction

endpackage

// File: rtl/s4ga_seg_ram.sv
// rtl/s4ga_seg_ram.sv - segment memory: host write port, registered stream read port
// Optional readback port enabled by S4GA_CFG_RDBACK_EN.
module s4ga_seg_ram #(
   parameter int DEPTH = 21,
   parameter int A_W   = 5,
   parameter int SI_W  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [A_W-1:0]  wr_addr,
   input  logic [SI_W-1:0] wr_data,
   input  logic            st_en,
   input  logic [A_W-1:0]  st_addr,
   output logic [SI_W-1:0] st_data
`ifdef S4GA_CFG_RDBACK_EN
   ,
   input  logic [A_W-1:0]  rd_addr,
   output logic [SI_W-1:0] rd_data
`endif
);

   logic [SI_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Stream output doubles as the streamer's so_si register; it reads zero when not issuing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_data <= '0;
      end else if (st_en) begin
         st_data <= mem[st_addr];
      end else begin
         st_data <= '0;
      end
   end

`ifdef S4GA_CFG_RDBACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (int'(rd_addr) < DEPTH) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end
`endif

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// rtl/s4ga_cfg_streamer.sv - replays stored LUT config frames into the s4ga engine after an N+1 reset window
// Optional host readback port enabled by S4GA_CFG_RDBACK_EN.
module s4ga_cfg_streamer
   import s4ga_pkg::*;
#(
   parameter  int N     = 101,
   parameter  int K     = 5,
   parameter  int SI_W  = 4,
   localparam int N_W   = calc_n_w(N),
   localparam int A_W   = calc_a_w(N, K, SI_W)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            wr_en,
   input  logic [A_W-1:0]  wr_addr,
   input  logic [SI_W-1:0] wr_data,
   output logic [SI_W-1:0] so_si,
   output logic            so_rst,
   output logic [N_W-1:0]  lut_idx,
   output logic            frame_done,
   output logic            sweep_done
`ifdef S4GA_CFG_RDBACK_EN
   ,
   input  logic [A_W-1:0]  rd_addr,
   output logic [SI_W-1:0] rd_data
`endif
);

   localparam int F     = calc_f(N, K, SI_W);
   localparam int DEPTH = calc_depth(N, K, SI_W);
   localparam int SEG_W = calc_clog2(F);
   localparam int CNT_W = calc_clog2(N + 1);

   state_t             state, next_state;
   logic [CNT_W-1:0]   rst_cnt;
   logic [A_W-1:0]     addr;
   logic [SEG_W-1:0]   seg_cnt;
   logic [N_W-1:0]     lut_cnt;
   logic               rst_done, issue, so_rst_d;
   logic               addr_last, seg_last, lut_last;

   assign rst_done  = (rst_cnt == CNT_W'(N));
   assign addr_last = (addr == A_W'(DEPTH - 1));
   assign seg_last  = (seg_cnt == SEG_W'(F - 1));
   assign lut_last  = (lut_cnt == N_W'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (run) next_state = ST_RSTW;
         ST_RSTW: begin
            if (!run)          next_state = ST_IDLE;
            else if (rst_done) next_state = ST_RUN;
         end
         ST_RUN:  if (!run) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // The last RSTW cycle already issues address 0 so mem[0] lands on the first RUN cycle.
   always_comb begin
      issue    = 1'b0;
      so_rst_d = (next_state != ST_RUN);
      case (state)
         ST_RSTW: issue = run && rst_done;
         ST_RUN:  issue = run;
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_cnt <= '0;
         addr    <= '0;
         seg_cnt <= '0;
         lut_cnt <= '0;
      end else begin
         if (state == ST_RSTW && next_state == ST_RSTW) begin
            rst_cnt <= rst_cnt + 1'b1;
         end else begin
            rst_cnt <= '0;
         end

         if (issue) begin
            addr    <= addr_last ? '0 : addr + 1'b1;
            seg_cnt <= seg_last ? '0 : seg_cnt + 1'b1;
            if (seg_last) begin
               lut_cnt <= lut_last ? '0 : lut_cnt + 1'b1;
            end
         end else if (next_state != ST_RUN) begin
            addr    <= '0;
            seg_cnt <= '0;
            lut_cnt <= '0;
         end
      end
   end

   // Tags registered on the same edge as the RAM read so they line up with so_si.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         so_rst     <= 1'b1;
         lut_idx    <= '0;
         frame_done <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         so_rst     <= so_rst_d;
         lut_idx    <= issue ? lut_cnt : '0;
         frame_done <= issue && seg_last;
         sweep_done <= issue && addr_last;
      end
   end

`ifdef S4GA_CFG_RDBACK_EN
   s4ga_seg_ram #(
      .DEPTH (DEPTH),
      .A_W   (A_W),
      .SI_W  (SI_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .st_en   (issue),
      .st_addr (addr),
      .st_data (so_si),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
`else
   s4ga_seg_ram #(
      .DEPTH (DEPTH),
      .A_W   (A_W),
      .SI_W  (SI_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .st_en   (issue),
      .st_addr (addr),
      .st_data (so_si)
   );
`endif

endmodule
